// File: rtl/regfile_dump_unit.sv
// Walks the register file debug read port and serialises each register as a
// 5-byte frame {addr, data MSB..LSB} on a valid/ready byte stream.
module regfile_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] sel_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                single_q, single_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        single_d    = single_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = single ? sel_addr : '0;
                    single_d = single;
                    busy_d   = 1'b1;
                    state_d  = S_LATCH;
                end
            end
            // One cycle after the address changes, so the combinational read has settled.
            S_LATCH: begin
                data_d      = debug_data;
                idx_d       = '0;
                out_data_d  = 8'(addr_q);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        // data_q is a shift register: its top byte is always the next to send.
                        out_data_d = data_q[DATA_W-1 -: 8];
                        data_d     = data_q << 8;
                        idx_d      = idx_q + 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        if (!single_q && (addr_q < LAST_ADDR)) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_LATCH;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            single_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            single_q    <= single_d;
        end
    end

    assign debug_addr = addr_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
Debug-side reader for the CPU register file. On a start request it walks the register file's combinational debug read port (debug_addr/debug_data) and serialises each register as a 5-byte frame on a valid/ready byte stream toward the PDU/UART transmitter. It supports a full dump of x0..x31 or a single selected register. It sits between the register file debug port and the debug output path, and only issues reads; it never writes registers.

Parameters:
NUM_REGS, 32, registers walked in a full dump (addresses 0..NUM_REGS-1)
ADDR_W, 5, width of debug_addr / sel_addr
DATA_W, 32, register width; frame carries DATA_W/8 = 4 data bytes

Ports:
clk  in  1  single clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
start  in  1  request a dump; sampled only in IDLE
single  in  1  sampled with start: 1 = dump sel_addr only, 0 = full dump
sel_addr  in  ADDR_W  register index for single mode; latched at start
busy  out  1  high while a dump is in progress
done  out  1  one-cycle pulse after the final byte of a dump is accepted
debug_addr  out  ADDR_W  address driven to the register file debug port
debug_data  in  DATA_W  combinational read data (x0 returns 0)
out_data  out  8  stream byte
out_valid  out  1  stream byte valid
out_ready  in  1  downstream accepts byte when out_valid & out_ready

Behaviour:
- Clock clk; reset rst, synchronous, active-high. Reset values: state IDLE, debug_addr 0, out_data 0, out_valid 0, busy 0, done 0, byte index 0.
- States: IDLE, LATCH, SEND, DONE.
- IDLE: start=1 at an edge sets debug_addr to sel_addr (single=1) or 0 (single=0), latches the mode, sets busy=1, and moves to LATCH. start=0 keeps the unit in IDLE.
- LATCH: on the next edge, capture debug_data into a DATA_W shift/hold register, set byte index 0 and out_valid=1, and move to SEND. The one-cycle gap lets the combinational debug read settle.
- SEND: the frame is byte0 = {3'b000, debug_addr}, then data[31:24], data[23:16], data[15:8], data[7:0] (MSB first).
- SEND advance: a byte advances only on an edge with out_valid & out_ready. out_data and out_valid are held stable while out_ready=0, with no drop and no duplicate.
- SEND after byte 4 is accepted:
  - Full mode with debug_addr < NUM_REGS-1: increment debug_addr, set out_valid=0, go to LATCH.
  - Otherwise (last register, or single mode): set out_valid=0 and busy=0, set done=1, go to DONE.
- DONE: lasts one cycle. done returns to 0 and the unit goes to IDLE; start is ignored in DONE.
- Latency: start is sampled at edge E0 and out_valid first rises after E1. Between registers there is exactly one out_valid=0 bubble cycle (LATCH).
- Full dump with out_ready held at 1: 32 x (1 LATCH + 5 SEND) = 192 cycles from E0 to the done pulse.
- start while busy (LATCH/SEND/DONE) is ignored and does not restart or queue a dump.
- debug_addr never wraps. The full dump ends at NUM_REGS-1 and the address is not incremented past it.
- Capture is per register at its LATCH cycle. The unit does not snapshot the whole register file atomically; with the CPU halted the dump is consistent.
- x0 is emitted as a normal frame: 00 00 00 00 00.
- rst mid-dump aborts immediately to the reset values on that edge, with no done pulse. A partially sent frame is not completed.
- sel_addr and single changes after start have no effect until the next dump.

Test Plan:
- Preload xN = 0x1000_0000+N, single=0, start pulse, out_ready=1 -> 160 bytes. Frame k is {k, 0x10, 0x00, 0x00, k}, except frame 0 is 00 00 00 00 00. done pulses once at cycle 192 after start; busy is high throughout.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly during a full dump -> the byte sequence is identical to the previous test. out_data is stable during every out_valid=1 & out_ready=0 cycle.
- Single mode: x7 = 0xDEADBEEF, sel_addr=7, single=1, start -> exactly bytes 07 DE AD BE EF. done pulses 1 cycle after the last handshake. debug_addr stays 7.
- start re-asserted during SEND of register 3 -> ignored; the dump continues to x31 with a single done pulse. A new start in the cycle after DONE begins a fresh dump.
- rst asserted during byte 2 of register 5 -> the next cycle shows out_valid=0, busy=0, done=0, debug_addr=0, with no further bytes. A subsequent start yields a complete, correct dump.
- Timing check: start sampled at E0 -> out_valid=0 during LATCH and =1 after E1. There is exactly one out_valid=0 cycle between consecutive frames when out_ready=1.
